// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the radix-2 Booth multipliers
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Counter must hold WIDTH+1 steps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  // Radix-2 recode of {q[0], q(-1)}.
  function automatic booth_op_t booth_recode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
// Ports:
//   acc       in   WIDTH+2  partial-product accumulator
//   q         in   WIDTH+1  multiplier shift register (extended operand)
//   q_m1      in   1        bit shifted out of q on the previous step
//   a         in   WIDTH+1  extended multiplicand
//   acc_next  out  WIDTH+2  accumulator after the step
//   q_next    out  WIDTH+1  multiplier register after the step
//   q_m1_next out  1        new q(-1)
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   a,
  output logic [WIDTH+1:0] acc_next,
  output logic [WIDTH:0]   q_next,
  output logic             q_m1_next
);

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] sum;
  booth_op_t        op;

  always_comb begin
    // One extra sign bit so subtracting the most-negative operand cannot overflow.
    a_ext = {a[WIDTH], a};
    op    = booth_recode(q[0], q_m1);
    case (op)
      BOOTH_ADD: sum = acc + a_ext;
      BOOTH_SUB: sum = acc - a_ext;
      default:   sum = acc;
    endcase
    // Arithmetic right shift of {sum, q, q_m1}.
    acc_next  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_next    = {sum[0], q[WIDTH:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential radix-2 Booth multiplier with valid/ready handshakes
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands and mode valid
//   in_ready   out  1        idle, able to accept operands
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        1 = two's-complement operands, 0 = unsigned
//   out_valid  out  1        product valid
//   out_ready  in   1        consumer accepts product
//   product    out  2*WIDTH  exact a*b in the captured mode
//   busy       out  1        operation in progress or result pending
module seq_booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int            CW    = cnt_width(WIDTH);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);

  state_t           state;
  logic [WIDTH+1:0] acc;
  logic [WIDTH:0]   q;
  logic [WIDTH:0]   m;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] acc_n;
  logic [WIDTH:0]   q_n;
  logic             q_m1_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .a         (m),
    .acc_next  (acc_n),
    .q_next    (q_n),
    .q_m1_next (q_m1_n)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Extending to WIDTH+1 bits lets one signed Booth datapath
            // serve both modes: unsigned operands become non-negative.
            m     <= {is_signed & a[WIDTH-1], a};
            q     <= {is_signed & b[WIDTH-1], b};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= STEPS;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Low 2*WIDTH bits of {acc, q} after the final step.
            product <= {acc_n[WIDTH-2:0], q_n};
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - self-checking bench for seq_booth_multiplier
module tb_seq_booth_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  logic        iv4 = 1'b0, ir4, s4 = 1'b0, ov4, or4 = 1'b1, busy4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  logic        iv16 = 1'b0, ir16, s16 = 1'b0, ov16, or16 = 1'b1, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );
  seq_booth_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );
  seq_booth_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
  );

  // Reference: extend to 64 bits per mode, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic [63:0] mask, ea, eb, pm;
    mask = (64'd1 << w) - 64'd1;
    ea = {48'd0, a} & mask;
    eb = {48'd0, b} & mask;
    if (s && a[w-1]) ea = ea | ~mask;
    if (s && b[w-1]) eb = eb | ~mask;
    pm = (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
    return pm[31:0];
  endfunction

  // Starts at a negedge; returns at the negedge where out_valid is seen (lat = edges after accept).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat);
    int n;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; a8 = 'x; b8 = 'x; s8 = 1'bx;
    lat = 0;
    while (!ov8 && lat < 60) begin @(posedge clk); @(negedge clk); lat++; end
    if (!ov8) lat = -1;
    p = p8;
  endtask

  task automatic take8();
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic b2b8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] p;
    logic [31:0] e;
    int lat;
    op8(a, b, s, p, lat);
    e = ref_mul(8, {8'd0, a}, {8'd0, b}, s);
    checks++;
    if (p !== e[15:0] || lat != 9) begin
      errors++;
      $display("FAIL w8_b2b a=%h b=%h s=%0d: got %h lat %0d, expected %h lat 9", a, b, s, p, lat, e[15:0]);
    end
  endtask

  task automatic b2b4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n, lat;
    logic [31:0] e;
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; a4 = 'x; b4 = 'x; s4 = 1'bx;
    lat = 0;
    while (!ov4 && lat < 60) begin @(posedge clk); @(negedge clk); lat++; end
    e = ref_mul(4, {12'd0, a}, {12'd0, b}, s);
    checks++;
    if (!ov4 || p4 !== e[7:0] || lat != 5) begin
      errors++;
      $display("FAIL w4_b2b a=%h b=%h s=%0d: got %h lat %0d, expected %h lat 5", a, b, s, p4, lat, e[7:0]);
    end
  endtask

  task automatic b2b16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n, lat;
    logic [31:0] e;
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    n = 0;
    while (!ir16 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0; a16 = 'x; b16 = 'x; s16 = 1'bx;
    lat = 0;
    while (!ov16 && lat < 60) begin @(posedge clk); @(negedge clk); lat++; end
    e = ref_mul(16, a, b, s);
    checks++;
    if (!ov16 || p16 !== e || lat != 17) begin
      errors++;
      $display("FAIL w16_b2b a=%h b=%h s=%0d: got %h lat %0d, expected %h lat 17", a, b, s, p16, lat, e);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b product=%h busy=%b, expected 0 0000 0", ov8, p8, busy8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ir4 !== 1'b1 || ir16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b%b, expected 111", ir8, ir4, ir16);
    end
  endtask

  task automatic test_directed();
    logic [15:0] p;
    int lat;
    op8(8'd5, 8'hFE, 1'b1, p, lat);
    checks++;
    if (p !== 16'hFFF6 || lat != 9) begin
      errors++;
      $display("FAIL signed_5xm2: got %h lat %0d, expected fff6 lat 9", p, lat);
    end
    checks++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: busy=%b in_ready=%b, expected 1 0", busy8, ir8);
    end
    take8();
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL handoff_idle: in_ready=%b ov=%b, expected 1 0", ir8, ov8);
    end
    op8(8'h80, 8'h80, 1'b1, p, lat); take8();
    checks++;
    if (p !== 16'h4000) begin errors++; $display("FAIL signed_min_min: got %h, expected 4000", p); end
    op8(8'h80, 8'h7F, 1'b1, p, lat); take8();
    checks++;
    if (p !== 16'hC080) begin errors++; $display("FAIL signed_min_max: got %h, expected c080", p); end
    op8(8'hFF, 8'hFF, 1'b0, p, lat); take8();
    checks++;
    if (p !== 16'hFE01) begin errors++; $display("FAIL unsigned_ff_ff: got %h, expected fe01", p); end
    op8(8'hFF, 8'hFF, 1'b1, p, lat); take8();
    checks++;
    if (p !== 16'h0001) begin errors++; $display("FAIL signed_ff_ff: got %h, expected 0001", p); end
  endtask

  task automatic test_back_pressure();
    logic [15:0] p;
    int lat;
    op8(8'd12, 8'd11, 1'b0, p, lat);
    checks++;
    if (p !== 16'h0084 || lat != 9) begin
      errors++;
      $display("FAIL bp_product: got %h lat %0d, expected 0084 lat 9", p, lat);
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 1) begin iv8 = 1'b1; a8 = 8'd2; b8 = 8'd2; s8 = 1'b0; end
      else iv8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b1 || p8 !== 16'h0084 || ir8 !== 1'b0 || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ov=%b product=%h in_ready=%b busy=%b, expected 1 0084 0 1",
                 i, ov8, p8, ir8, busy8);
      end
    end
    iv8 = 1'b0;
    take8();
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0084) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b ov=%b busy=%b product=%h, expected 1 0 0 0084", ir8, ov8, busy8, p8);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL bp_no_stale_accept: busy=%b, expected 0", busy8); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    a8 = 8'd7; b8 = 8'd9; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b product=%h, expected 0 0000", ov8, p8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || busy8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: in_ready=%b busy=%b ov=%b, expected 1 0 0", ir8, busy8, ov8);
    end
    op8(8'd3, 8'd4, 1'b0, p, lat);
    take8();
    checks++;
    if (p !== 16'h000C || lat != 9) begin
      errors++;
      $display("FAIL after_reset_3x4: got %h lat %0d, expected 000c lat 9", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  c8  [5] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
    logic [15:0] c16 [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [31:0] r;
    or8 = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) b2b8(c8[i], c8[j], s[0]);
    for (int k = 0; k < 20; k++) begin
      r = $urandom;
      b2b8(r[7:0], r[15:8], r[16]);
    end
    or8 = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          logic [31:0] ai, bj;
          ai = i; bj = j;
          b2b4(ai[3:0], bj[3:0], s[0]);
        end
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) b2b16(c16[i], c16[j], s[0]);
    for (int k = 0; k < 20; k++) begin
      r = $urandom;
      b2b16(r[15:0], r[31:16], k[0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised, clocked successor to the team's combinational 8-bit radix-2 Booth multiplier. Computes the product of two WIDTH-bit operands iteratively, one Booth step per clock, selectable signed or unsigned per operation. Input and result are exchanged over valid/ready handshakes so the block drops into datapaths with back-pressure, such as the ALU, MAC and filter blocks.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block idle and able to accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b, exact, signed or unsigned per captured mode
busy  output  1  high in CALC or DONE

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, out_valid = 0, product = 0, iteration counter = 0.
  - in_ready = 1 once reset is released.
- States: IDLE, CALC, DONE.
  - in_ready = (state == IDLE).
  - busy = (state != IDLE).
  - out_valid = (state == DONE).
- IDLE: on in_valid && in_ready at a rising edge:
  - Capture a, b and is_signed.
  - Extend both operands to WIDTH+1 bits: sign-extend if is_signed, else zero-extend.
  - Clear accumulator and Q(-1); load counter with WIDTH+1; go to CALC.
  - Operand changes while not in IDLE are ignored.
- CALC: one radix-2 Booth step per cycle.
  - Recode {q[0], Q(-1)}: 01 -> acc += A; 10 -> acc -= A; 00 and 11 -> no change.
  - Then arithmetic right shift of {acc, q, Q(-1)} by 1.
  - Decrement the counter. When it reaches 0, register the low 2*WIDTH bits of {acc, q} into product and go to DONE.
- Arithmetic width: the accumulator is WIDTH+2 bits so that subtracting the most-negative operand cannot overflow. The result is exact for every operand pair in both modes.
- Latency: operands accepted at edge k -> out_valid high after edge k+WIDTH+1. Fixed, and independent of data and mode.
- DONE:
  - product and out_valid are held stable until out_valid && out_ready at a rising edge.
  - On that edge go to IDLE; in_ready rises in the following cycle.
  - There is no overlap: the next operands cannot be accepted in the same cycle the result is taken. Throughput is one result per WIDTH+3 cycles under no back-pressure.
- product keeps its last value after hand-off until the next result is registered.
- in_valid asserted in CALC or DONE is not accepted. The producer must hold it until in_ready is high.
- Reset mid-CALC or mid-DONE aborts the operation: no out_valid pulse, product = 0, back to IDLE.
- X on a/b while not in IDLE must not propagate into state.

Decomposition:
- Shared package/header booth_pkg holds:
  - State encodings IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Booth recode constants BOOTH_NOP, BOOTH_ADD, BOOTH_SUB.
  - A function/macro for counter width, clog2(WIDTH+2).
- One natural sub-module, booth_step: purely combinational single step.
  - Inputs: acc, q, q_m1, A.
  - Outputs: next acc, q, q_m1 after add/sub and arithmetic shift.
  - Reused later by a fully unrolled/pipelined variant.

Test Plan:
1. WIDTH=8, signed, a=5, b=-2 (8'hFE) -> out_valid exactly 9 cycles after accept, product = 16'hFFF6 (-10).
2. WIDTH=8, signed, a=-128, b=-128 -> product = 16'h4000 (16384). Also a=-128, b=127 -> 16'hC080 (-16256).
3. WIDTH=8, unsigned, a=255, b=255 -> product = 16'hFE01 (65025). Same bits with is_signed=1 -> 16'h0001.
4. Back-pressure: out_ready held low 20 cycles after out_valid -> product, out_valid stable, in_ready low, in_valid pulses ignored. On out_ready: in_ready high the next cycle.
5. Reset mid-operation: rst_n low 3 cycles after accept of a=7, b=9 -> immediately out_valid=0, product=0, in_ready=1 after release. A new operation 3*4 gives 12 with normal latency.
6. Randomised plus corners at WIDTH=4, 8 and 16: 0, 1, -1, min, max, both modes, back-to-back with out_ready tied high -> every product matches the reference model, with the fixed latency of WIDTH+1 cycles.
